// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the run-time reprogrammable
// clock divider (clkdiv_ctrl and clkdiv_phase).
//   state_e  : controller states
//   MIN_DIV  : smallest legal divide ratio
//   hi_phase : length of the high phase for a given ratio
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam int MIN_DIV = 2;

    // High phase is floor(D/2); the low phase takes the extra cycle of odd ratios.
    function automatic logic [31:0] hi_phase(input logic [31:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_phase.sv
// clkdiv_phase: phase counter, registered clock output and period-boundary
// detection for clkdiv_ctrl.
//   clk_i, rst_n : clock, synchronous active-low reset
//   run          : keep (or start) dividing after this edge; low parks cnt/clk_o at 0
//   div          : ratio of the period currently in progress
//   clk_o        : divided clock, straight from a flop
//   boundary     : this edge ends the current period (cnt == div-1)
module clkdiv_phase
    import clkdiv_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          run,
    input  logic [CW-1:0] div,
    output logic          clk_o,
    output logic          boundary
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          live;   // a period is in progress (cnt is meaningful)
    logic          clk_d;

    assign boundary = live && (cnt == div - CW'(1));

    // The first run cycle after idle only starts a period (cnt_next = 0), so
    // clk_o rises one edge after the controller leaves IDLE with a full high phase.
    always_comb begin
        cnt_next = '0;
        if (run && live && !boundary)
            cnt_next = cnt + CW'(1);
        // At a wrap cnt_next is 0 and any legal ratio has H >= 1, so the
        // old/new ratio question at a PEND boundary does not matter here.
        clk_d = run && (32'(cnt_next) < hi_phase(32'(div)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt   <= '0;
            live  <= 1'b0;
            clk_o <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            live  <= run;
            clk_o <= clk_d;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time reprogrammable clock divider. Ratio changes and
// start/stop take effect only on period boundaries, so clk_o has no runts
// (except when reset truncates a period).
//   clk_i, rst_n            : clock, synchronous active-low reset
//   en_i                    : run request (level)
//   div_i/div_valid_i/div_ready_o : ratio request handshake
//   clk_o                   : divided clock
//   cur_div_o               : ratio currently in effect
//   busy_o                  : controller in RUN, PEND or STOP
//   err_o                   : one-cycle pulse on an accepted illegal ratio
//   periods_o               : completed periods (saturating)
// Optional: define CLKDIV_CTRL_STATS_EN to build the period counter;
// otherwise periods_o is tied to 0.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CW          = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [CW-1:0] div_i,
    input  logic          div_valid_i,
    output logic          div_ready_o,
    output logic          clk_o,
    output logic [CW-1:0] cur_div_o,
    output logic          busy_o,
    output logic          err_o,
    output logic [31:0]   periods_o
);

    state_e        state;
    state_e        state_nxt;
    logic [CW-1:0] cur_div;
    logic [CW-1:0] div_pend;
    logic          accept;
    logic          legal;
    logic          run;
    logic          boundary;

    assign div_ready_o = (state == ST_IDLE) || (state == ST_RUN);
    assign accept      = div_valid_i && div_ready_o;
    assign legal       = (div_i >= CW'(MIN_DIV));
    assign cur_div_o   = cur_div;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en_i) state_nxt = ST_RUN;
            // A legal request wins over en_i falling; PEND resolves the stop.
            ST_RUN: begin
                if (accept && legal) state_nxt = ST_PEND;
                else if (!en_i)      state_nxt = ST_STOP;
            end
            ST_PEND: if (boundary) state_nxt = en_i ? ST_RUN : ST_IDLE;
            // en_i back high cancels the stop without touching the phase.
            ST_STOP: begin
                if (en_i)          state_nxt = ST_RUN;
                else if (boundary) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Leaving to IDLE only ever happens on a boundary, so dropping run there
    // parks clk_o low exactly at the end of a whole period.
    assign run = (state != ST_IDLE) && (state_nxt != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_div  <= CW'(DEFAULT_DIV);
            div_pend <= CW'(DEFAULT_DIV);
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != ST_IDLE);
            err_o  <= accept && !legal;
            if (state == ST_IDLE && accept && legal)
                cur_div <= div_i;
            if (state == ST_RUN && accept && legal)
                div_pend <= div_i;
            if (state == ST_PEND && boundary)
                cur_div <= div_pend;
        end
    end

    clkdiv_phase #(.CW(CW)) u_phase (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .run      (run),
        .div      (cur_div),
        .clk_o    (clk_o),
        .boundary (boundary)
    );

`ifdef CLKDIV_CTRL_STATS_EN
    logic [31:0] periods;

    // boundary is only asserted while a period is live, i.e. in RUN/PEND/STOP.
    always_ff @(posedge clk_i) begin
        if (!rst_n)
            periods <= '0;
        else if (boundary && (periods != 32'hFFFF_FFFF))
            periods <= periods + 32'd1;
    end

    assign periods_o = periods;
`else
    assign periods_o = 32'd0;
`endif

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Runtime-reprogrammable clock-divider controller. Produces a divided clock from `clk_i` whose ratio is changed through a valid/ready request port, with every ratio change and every start/stop applied only on a period boundary, so `clk_o` never emits a runt pulse. It sits between the glitch-sequencing logic and the divided-clock consumers, replacing fixed-ratio dividers wherever the ratio must change at run time.

## Interface
- `CW`, default 8: width of the divide ratio and of the phase counter.
- `DEFAULT_DIV`, default 2: ratio loaded at reset; must be ≥ 2.
- `clk_i`  in  1: the single clock; all logic runs on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `en_i`  in  1: run request; level-sensitive.
- `div_i`  in  CW: requested divide ratio.
- `div_valid_i`  in  1: ratio request valid.
- `div_ready_o`  out  1: controller can accept a ratio request.
- `clk_o`  out  1: divided clock, driven directly by a flop.
- `cur_div_o`  out  CW: ratio currently in effect.
- `busy_o`  out  1: high in RUN, PEND or STOP.
- `err_o`  out  1: one-cycle pulse when an illegal ratio (< 2) is accepted.
- `periods_o`  out  32: count of completed `clk_o` periods (see Configuration).

## Operation
- Ratio D gives period D `clk_i` cycles: high phase H = D>>1 cycles, low phase D−H cycles. For example, D=3 is high 1, low 2; D=4 is high 2, low 2.
- Phase counter `cnt` runs 0..D−1. The `clk_o` flop loads `(cnt_next < H)`, where `cnt_next` is the next value of `cnt`. `cnt` wraps from D−1 to 0, and the wrap is the period boundary.
- **IDLE:**
  - `clk_o` = 0 and `cnt` = 0.
  - If `en_i` is high, go to RUN. `clk_o` rises on the next edge, so the first high phase is complete.
- **RUN:**
  - Divides continuously.
  - Accepting a legal request stores it in `div_pend` and moves to PEND.
  - `en_i` low moves to STOP.
- **PEND:**
  - Waits for the boundary. At the boundary, `div_pend` becomes `cur_div`, `cnt` = 0, and the state returns to RUN.
  - If `en_i` is low at the boundary, the new ratio is still applied, then the state goes to IDLE.
- **STOP:**
  - Finishes the current period. At the boundary, go to IDLE with `clk_o` held low.
  - `en_i` returning high before the boundary cancels the stop and returns to RUN with no phase disturbance.
- **Request port:**
  - `div_ready_o` = 1 in IDLE and RUN, 0 in PEND and STOP.
  - A request transfers on `div_valid_i & div_ready_o`.
  - In IDLE, a legal ratio loads `cur_div` on the next edge.
  - Illegal ratios (0 or 1) complete the handshake, are discarded, and pulse `err_o` for 1 cycle. State and ratio are unchanged.
- **Simultaneous events:**
  - A request and `en_i` rising in IDLE in the same cycle: the new ratio applies to the first period.
  - A request and `en_i` falling in RUN in the same cycle: the request is accepted and the state goes to PEND, which then resolves as described above.
- **Reset mid-operation:** aborts the current period immediately. `clk_o` drops to 0 on the reset edge. A truncated high phase is acceptable only under reset.

## Timing
- Reset values: state IDLE, `cnt` 0, `clk_o` 0, `cur_div_o` = DEFAULT_DIV, `div_ready_o` 1, `busy_o` 0, `err_o` 0, `periods_o` 0.
- `en_i` sampled high at edge N: `clk_o` = 1 after edge N+1.
- A ratio change accepted at edge N in RUN takes effect at the first boundary after N, at the latest D cycles later.
- `cur_div_o` updates on the same edge the new period starts.
- `err_o` is high for the cycle after the accepting edge.
- All outputs are registered except `div_ready_o`, which decodes directly from the state register.

## Configuration
- Macro: `CLKDIV_CTRL_STATS_EN`.
- Defined: `periods_o` increments at every period boundary reached in RUN, PEND or STOP. It saturates at 2^32−1 and clears only on reset.
- Undefined: `periods_o` is tied to 0 and no counter is synthesized. The port list is identical either way.

## Structure
- Package `clkdiv_pkg` holds:
  - the state enum (IDLE, RUN, PEND, STOP);
  - `MIN_DIV` = 2;
  - the high-phase function H(D) = D>>1.
- Sub-module `clkdiv_phase` contains `cnt`, the `clk_o` flop and boundary detection. It is driven by the FSM in `clkdiv_ctrl` through `run`, `div` and `boundary` signals.

## Test plan
- **Reset and start:** hold `rst_n`=0 for 4 cycles, then raise `en_i` with DEFAULT_DIV=2. Expect `clk_o` to toggle every cycle, starting high one cycle after `en_i`, and `cur_div_o`=2.
- **Odd ratio:** request D=3 in IDLE, then enable. Expect `clk_o` high 1 cycle, low 2 cycles, repeating.
- **Change mid-run:** running at D=4 with `cnt`=1, request D=6. Expect `div_ready_o` to go 0, D=4 to finish its period, then a clean high-3/low-3 period, and `div_ready_o` back to 1.
- **Illegal ratio:** request D=1 while running at D=4. Expect a 1-cycle `err_o` pulse, `cur_div_o` to stay 4, and the waveform unchanged.
- **Stop and cancel:** drop `en_i` at `cnt`=0 with D=8 and raise it again 2 cycles later. Expect no gap in the waveform. Dropping `en_i` and holding it low must give `clk_o` low from the boundary onward with `busy_o`=0.
- **Stats:** with `CLKDIV_CTRL_STATS_EN`, run 10 periods at D=2, then assert reset mid-period. Expect `periods_o`=10 before reset, then 0 with `clk_o`=0 on the reset edge.
